// File: rtl/txeread.sv
// txeread: transmit-side packet reader.
// Reads a packet from the transmit packet memory (32-bit words, first byte in
// the MSB) and emits it as a nibble stream, low nibble of each byte first.
// Optional feature macro: TXEREAD_PAD_EN pads short packets (len < 60 bytes)
// with zero nibbles up to 120 nibbles.
//
// Stream handshake: o_v/o_d form a registered source paced by i_ce. Every
// i_ce edge in SEND presents a new nibble on o_d with o_v high. Between i_ce
// pulses o_v/o_d hold. o_v falls on the i_ce edge that also pulses o_done.
// Memory handshake: o_rd is a one-clock strobe with o_raddr; i_rdata is
// consumed exactly one clock later, independent of i_ce.
module txeread #(
    parameter int AW = 12
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_cmd,
    input  logic [AW+1:0] i_len,
    input  logic          i_cancel,
    output logic          o_busy,
    output logic          o_rd,
    output logic [AW-1:0] o_raddr,
    input  logic [31:0]   i_rdata,
    output logic          o_v,
    output logic [3:0]    o_d,
    output logic          o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [AW+1:0] r_len;       // packet length in bytes
    logic [AW+2:0] r_nib;       // index of the next nibble to emit
    logic [31:0]   r_shift;     // word currently being emitted
    logic [31:0]   r_hold;      // prefetched next word
    logic          r_rd_pend;   // a read response arrives this clock
    logic          r_fetch_ph;  // second clock of FETCH

    logic          w_accept;
    logic [AW-1:0] w_last_word;
    logic [AW+2:0] w_data_nibs;
    logic [AW+2:0] w_total;
    logic          w_is_last;
    logic          w_word_end;
    logic [AW:0]   w_next_word;
    logic          w_more;
    logic [3:0]    w_nib;
    logic [3:0]    w_nib_out;

    assign w_accept    = i_cmd && (i_len != '0);
    assign w_last_word = AW'((r_len - 1'b1) >> 2);
    assign w_data_nibs = {r_len, 1'b0};

`ifdef TXEREAD_PAD_EN
    localparam logic [AW+1:0] PAD_LEN  = (AW+2)'(60);
    localparam logic [AW+2:0] PAD_NIBS = (AW+3)'(120);
    assign w_total   = (r_len < PAD_LEN) ? PAD_NIBS : w_data_nibs;
    // padding nibbles beyond the real data are forced to zero
    assign w_nib_out = (r_nib >= w_data_nibs) ? 4'h0 : w_nib;
`else
    assign w_total   = w_data_nibs;
    assign w_nib_out = w_nib;
`endif

    assign w_is_last   = (r_nib == (w_total - 1'b1));
    assign w_word_end  = (r_nib[2:0] == 3'd7);
    // word after the one in the holding buffer
    assign w_next_word = {1'b0, r_nib[AW+2:3]} + (AW+1)'(2);
    assign w_more      = (w_next_word <= {1'b0, w_last_word});

    // nibble select: bytes MSB first, low nibble of each byte first
    always_comb begin
        w_nib = r_shift[7:4];
        case (r_nib[2:0])
            3'd0:    w_nib = r_shift[27:24];
            3'd1:    w_nib = r_shift[31:28];
            3'd2:    w_nib = r_shift[19:16];
            3'd3:    w_nib = r_shift[23:20];
            3'd4:    w_nib = r_shift[11:8];
            3'd5:    w_nib = r_shift[15:12];
            3'd6:    w_nib = r_shift[3:0];
            default: w_nib = r_shift[7:4];
        endcase
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // next-state logic; cancel overrides every non-idle transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_FETCH;
            S_FETCH: if (r_fetch_ph) w_next = S_SEND;
            S_SEND:  if (i_ce && w_is_last) w_next = S_FLUSH;
            S_FLUSH: if (i_ce) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && i_cancel) w_next = S_IDLE;
    end

    // datapath: reads, word buffers, nibble output and status flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_busy     <= 1'b0;
            o_rd       <= 1'b0;
            o_raddr    <= '0;
            o_v        <= 1'b0;
            o_d        <= 4'h0;
            o_done     <= 1'b0;
            r_len      <= '0;
            r_nib      <= '0;
            r_shift    <= '0;
            r_hold     <= '0;
            r_rd_pend  <= 1'b0;
            r_fetch_ph <= 1'b0;
        end else begin
            o_rd      <= 1'b0;
            o_done    <= 1'b0;
            r_rd_pend <= o_rd;

            // word 0 lands in the shift register, later words in the holding buffer
            if (r_rd_pend) begin
                if (r_state == S_FETCH) r_shift <= i_rdata;
                else                    r_hold  <= i_rdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_len      <= i_len;
                        r_nib      <= '0;
                        r_fetch_ph <= 1'b0;
                        o_busy     <= 1'b1;
                        o_rd       <= 1'b1;
                        o_raddr    <= '0;
                    end
                end
                S_FETCH: begin
                    if (!r_fetch_ph) begin
                        r_fetch_ph <= 1'b1;
                        if (w_last_word != '0) begin
                            o_rd    <= 1'b1;
                            o_raddr <= AW'(1);
                        end
                    end
                end
                S_SEND: begin
                    if (i_ce) begin
                        o_v   <= 1'b1;
                        o_d   <= w_nib_out;
                        r_nib <= r_nib + 1'b1;
                        if (w_word_end) begin
                            r_shift <= r_hold;
                            if (w_more) begin
                                o_rd    <= 1'b1;
                                o_raddr <= w_next_word[AW-1:0];
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (i_ce) begin
                        o_v    <= 1'b0;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end
                end
                default: ;
            endcase

            if ((r_state != S_IDLE) && i_cancel) begin
                o_v       <= 1'b0;
                o_rd      <= 1'b0;
                o_busy    <= 1'b0;
                o_done    <= 1'b0;
                r_rd_pend <= 1'b0;
            end
        end
    end

endmodule

// File: doc/txeread.md
# txeread

Transmit-side packet reader for the Ethernet MAC. It reads a packet that software has stored in the transmit packet memory as 32-bit words, first byte in the MSB. It then emits the packet as a nibble stream, one nibble per `i_ce`, to the downstream transmit filter chain (preamble/CRC insertion). Within each byte the low nibble goes out first, matching the receive-side packing so that a received buffer can be re-transmitted unmodified.

## Interface
- `AW`, default 12: word-address width of the packet memory; byte length field is `AW+2` bits.
- `i_clk` input 1: system clock.
- `i_reset` input 1: synchronous, active-high reset.
- `i_ce` input 1: nibble strobe; at most one nibble advances per asserted clock.
- `i_cmd` input 1: start request; sampled only in IDLE.
- `i_len` input AW+2: packet length in bytes, sampled with `i_cmd`.
- `i_cancel` input 1: abort current packet.
- `o_busy` output 1: high from command acceptance until return to IDLE.
- `o_rd` output 1: memory read strobe.
- `o_raddr` output AW: word address of the read.
- `i_rdata` input 32: memory data; valid exactly one clock after `o_rd`, independent of `i_ce`.
- `o_v` output 1: nibble valid.
- `o_d` output 4: nibble data.
- `o_done` output 1: one-clock pulse on normal completion.

Reset: every output 0, state IDLE.

## Operation
- States: IDLE, FETCH, SEND, FLUSH.
- **IDLE:** `i_cmd` with `i_len != 0` latches the length, zeroes the word and nibble counters, and sets `o_busy`, then FETCH. `i_cmd` with `i_len == 0` is ignored.
- **FETCH:** issue a read of word 0. Capture `i_rdata` into the shift register. Issue a prefetch read of word 1 into the holding buffer if the packet extends past word 0. Go to SEND.
- **SEND:**
  - On each `i_ce`, drive `o_v=1` and `o_d` with the next nibble of the word, in nibble order 27:24, 31:28, 19:16, 23:20, 11:8, 15:12, 3:0, 7:4.
  - Example: word 0x12345678 emits 2,1,4,3,6,5,8,7.
  - After the 8th nibble of a word, the holding buffer moves to the shift register. The next word read is issued the same clock.
  - Reads are never issued past word `(len-1)>>2`.
- The last nibble is nibble `2*len-1`; odd byte counts and partial final words are legal. The next `i_ce` goes to FLUSH.
- **FLUSH:** on `i_ce`, set `o_v<=0`, pulse `o_done`, clear `o_busy`, and go to IDLE.
- `o_v` stays high across a packet; gaps between `i_ce` pulses hold `o_v`/`o_d` unchanged.
- **Cancel:** `i_cancel` in any non-IDLE state takes effect at the next clock edge regardless of `i_ce`. It clears `o_v`, `o_rd` and `o_busy`, gives no `o_done`, and returns to IDLE. A buffered read response is discarded.
- **Precedence:** `i_reset` beats `i_cancel`, which beats `i_cmd`. `i_cmd` while busy is ignored.

## Timing
- Let acceptance edge be T0.
  - `o_rd=1`, `o_raddr=0` during the clock after T0.
  - Word 0 is captured at T0+2.
  - The first `o_v` rises at the first `i_ce` edge at or after T0+3.
- No underrun with `i_ce` continuously high: the prefetch completes 7 clocks before it is needed.
- `o_rd` is a single-clock pulse per word; `o_raddr` holds until the next read.
- Total valid nibbles equal `2*len` (or the padded count). `o_done` occurs exactly one `i_ce` after the last valid nibble.
- A back-to-back command is accepted on the clock after `o_done`.

## Configuration
- Macro: `TXEREAD_PAD_EN`.
- **Defined:** packets with `len < 60` are extended to 120 nibbles.
  - Nibbles beyond `2*len` are 0.
  - No memory reads are issued for padding.
  - `o_done` follows nibble 119.
- **Undefined:** exactly `2*len` nibbles are sent, with no padding logic.

## Test plan
- `len=4`, word0=0x12345678, `i_ce` always high: `o_rd` once at addr 0; `o_d`=2,1,4,3,6,5,8,7 with `o_v` high 8 clocks; then `o_done` 1 clock.
- `len=5`, word0=0xAABBCCDD, word1=0xEE000000, `i_ce` every 4th clock: 10 nibbles A,A,B,B,C,C,D,D,E,E; reads at addr 0 and 1 only.
- `len=64`, continuous `i_ce`: 128 consecutive valid nibbles with no gap; 16 reads at addresses 0..15.
- Cancel after nibble 5 of `len=16`: `o_v` and `o_busy` low next clock; no `o_done`; a new `i_cmd` two clocks later runs normally.
- `i_cmd` with `len=0`, and `i_cmd` while busy: both ignored, with no reads and no state change. Reset mid-packet: all outputs 0 next clock.
- With `TXEREAD_PAD_EN`, `len=2` of 0x1234xxxx: nibbles 2,1,4,3 then 116 zeros; `o_done` after nibble 119; one read only.
